mem_block_fill: RTL and testbench

- Initiator side of the byte-addressable 16-bit memory interface.
- On a cache miss, issues a burst of word reads for one cache block and collects the returned words in order.
- Streams each returned word into the cache data array, then writes the tag on the final word.
- Sits between the I/D-cache miss logic and the shared memory.

---
 rtl/mem_block_fill_if.sv | 33 +++
 rtl/mem_block_fill.sv | 130 +++++++++++++
 tb/tb_mem_block_fill.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_block_fill_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_block_fill_if
// Purpose  : Byte-addressable 16-bit memory read bus between a fill engine
//            (master) and the shared memory (slave).
// Revision : 1.0
// ============================================================================
interface mem_block_fill_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  mem_enable;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic                  memory_data_valid;
    logic [15:0]           memory_data;

    modport master (
        output mem_enable,
        output mem_wr,
        output memory_address,
        input  memory_data_valid,
        input  memory_data
    );

    modport slave (
        input  mem_enable,
        input  mem_wr,
        input  memory_address,
        output memory_data_valid,
        output memory_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_block_fill.sv
`default_nettype none
// ============================================================================
// Module   : mem_block_fill
// Purpose  : Cache-miss block fill: bursts word reads for one block, streams
//            returned words into the data array, writes the tag on the last.
//            Optional macro MEM_FILL_CRITICAL_WORD_FIRST_EN: wrap order
//            starting at the missing word.
// Revision : 1.0
// ============================================================================
module mem_block_fill #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  miss_detected,
    input  wire logic [ADDR_WIDTH-1:0] miss_address,
    output logic                       fsm_busy,
    output logic                       write_data_array,
    output logic                       write_tag_array,
    output logic [IDX_W-1:0]           cache_word_idx,
    output logic [15:0]                cache_data,
    mem_block_fill_if.master           mem
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int                    c_cnt_w       = IDX_W + 1;
    localparam logic [c_cnt_w-1:0]    c_block_words = c_cnt_w'(BLOCK_WORDS);
    localparam logic [IDX_W-1:0]      c_last_ret    = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_low_mask    = ADDR_WIDTH'((1 << (IDX_W + 1)) - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [c_cnt_w-1:0]    r_iss_cnt;
    logic [IDX_W-1:0]      r_ret_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [IDX_W-1:0]      w_iss_word;
    logic [IDX_W-1:0]      w_ret_word;

`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0] r_start;
    // IDX_W-bit adds wrap naturally at the block boundary.
    assign w_iss_word = r_start + r_iss_cnt[IDX_W-1:0];
    assign w_ret_word = r_start + r_ret_cnt;
`else
    assign w_iss_word = r_iss_cnt[IDX_W-1:0];
    assign w_ret_word = r_ret_cnt;
`endif

    assign mem.mem_wr = 1'b0;
    assign cache_data = mem.memory_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        fsm_busy           = 1'b0;
        mem.mem_enable     = 1'b0;
        mem.memory_address = '0;
        write_data_array   = 1'b0;
        write_tag_array    = 1'b0;
        cache_word_idx     = '0;
        case (r_state)
            IDLE: begin
                // Busy in the miss cycle itself so the pipeline stalls at once.
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (r_iss_cnt < c_block_words) begin
                    mem.mem_enable     = 1'b1;
                    mem.memory_address = r_base | ADDR_WIDTH'({w_iss_word, 1'b0});
                end
                if (mem.memory_data_valid) begin
                    write_data_array = 1'b1;
                    cache_word_idx   = w_ret_word;
                    if (r_ret_cnt == c_last_ret) begin
                        write_tag_array = 1'b1;
                        w_state_next    = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_cnt <= '0;
            r_ret_cnt <= '0;
            r_base    <= '0;
`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
            r_start   <= '0;
`endif
        end else if (r_state == IDLE) begin
            if (miss_detected) begin
                r_base    <= miss_address & ~c_low_mask;
`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
                r_start   <= miss_address[IDX_W:1];
`endif
                r_iss_cnt <= '0;
                r_ret_cnt <= '0;
            end
        end else if (write_tag_array) begin
            r_iss_cnt <= '0;
            r_ret_cnt <= '0;
        end else begin
            if (mem.mem_enable) begin
                r_iss_cnt <= r_iss_cnt + 1'b1;
            end
            if (write_data_array) begin
                r_ret_cnt <= r_ret_cnt + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_block_fill.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_block_fill
// Purpose  : Directed plus randomized fills of mem_block_fill against a
//            schedule-based reference model of issue/return ordering.
// Revision : 1.0
// ============================================================================
module tb_mem_block_fill;
    localparam int BW  = 8;
    localparam int IDX = $clog2(BW);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           miss_detected = 1'b0;
    logic [15:0]    miss_address = 16'h0;
    logic           fsm_busy;
    logic           write_data_array;
    logic           write_tag_array;
    logic [IDX-1:0] cache_word_idx;
    logic [15:0]    cache_data;
    logic [15:0]    drv_data = 16'h0;
    int             n_cmp = 0;
    int             n_bad = 0;

    mem_block_fill_if #(.ADDR_WIDTH(16)) bus ();

    mem_block_fill #(
        .ADDR_WIDTH (16),
        .BLOCK_WORDS(BW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .miss_detected   (miss_detected),
        .miss_address    (miss_address),
        .fsm_busy        (fsm_busy),
        .write_data_array(write_data_array),
        .write_tag_array (write_tag_array),
        .cache_word_idx  (cache_word_idx),
        .cache_data      (cache_data),
        .mem             (bus)
    );

    always #5 clk = ~clk;

    // Word slot for the n-th issue/return of a fill missing at byte address a.
    function automatic int word_of(input int n, input logic [15:0] a);
`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
        return (int'(a >> 1) + n) % BW;
`else
        return (n + 0 * int'(a)) % BW;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic m, input logic [15:0] ma,
                          input logic v, input logic [15:0] d);
        rst                   = r;
        miss_detected         = m;
        miss_address          = ma;
        bus.memory_data_valid = v;
        bus.memory_data       = d;
        drv_data              = d;
    endtask

    // Called at posedge+1 with inputs already driven; leaves at next posedge+1.
    task automatic check_cycle(input string tag, input logic busy, input logic en,
                               input logic [15:0] addr, input logic wda,
                               input int idx, input logic tag_w);
        @(negedge clk);
        chk({tag, ".busy"}, 32'(fsm_busy),             32'(busy));
        chk({tag, ".en"},   32'(bus.mem_enable),       32'(en));
        chk({tag, ".wr"},   32'(bus.mem_wr),           32'h0);
        chk({tag, ".addr"}, 32'(bus.memory_address),   32'(addr));
        chk({tag, ".wda"},  32'(write_data_array),     32'(wda));
        chk({tag, ".idx"},  32'(cache_word_idx),       32'(idx));
        chk({tag, ".data"}, 32'(cache_data),           32'(drv_data));
        chk({tag, ".tag"},  32'(write_tag_array),      32'(tag_w));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        set_in(1'b0, 1'b0, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
        check_cycle("idle", 1'b0, 1'b0, 16'h0, 1'b0, 0, 1'b0);
    endtask

    // lat >= 0: fixed latency; lat < 0: random in-order returns.
    // abort_k >= 0: assert rst alongside the abort_k-th return (0-based).
    task automatic do_fill(input logic [15:0] a, input int lat, input int abort_k);
        int          rt[BW];
        int          c;
        int          k;
        logic        v;
        logic [15:0] base;
        logic [15:0] addr;
        base = a & ~16'(2 * BW - 1);
        for (int n = 0; n < BW; n++) begin
            if (lat >= 0)   rt[n] = n + lat;
            else if (n == 0) rt[n] = int'($urandom_range(0, 4));
            else            rt[n] = rt[n-1] + 1 + int'($urandom_range(0, 2));
        end
        set_in(1'b0, 1'b1, a, 1'($urandom_range(0, 1)), 16'($urandom));
        check_cycle($sformatf("miss%04h", a), 1'b1, 1'b0, 16'h0, 1'b0, 0, 1'b0);
        c = 0;
        k = 0;
        while (k < BW) begin
            v = (rt[k] == c);
            set_in(v && (abort_k == k), 1'($urandom_range(0, 1)), 16'($urandom), v,
                   v ? 16'($urandom) : 16'h0);
            addr = (c < BW) ? (base | 16'(word_of(c, a) * 2)) : 16'h0;
            check_cycle($sformatf("fill%04h.c%0d", a, c), 1'b1, c < BW, addr, v,
                        v ? word_of(k, a) : 0, v && (k == BW - 1));
            if (v && (abort_k == k)) begin
                set_in(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
                check_cycle("post_abort", 1'b0, 1'b0, 16'h0, 1'b0, 0, 1'b0);
                return;
            end
            if (v) k++;
            c++;
        end
    endtask

    initial begin
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'h0;
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        check_cycle("reset", 1'b0, 1'b0, 16'h0, 1'b0, 0, 1'b0);

        do_fill(16'h1236, 4, -1);
        idle_cycle();
        do_fill(16'h00FE, 0, -1);
        idle_cycle();
        do_fill(16'h4000, -1, 2);
        do_fill(16'h5002, -1, -1);
        idle_cycle();
        do_fill(16'h123A, 2, -1);
        idle_cycle();

        for (int i = 0; i < 25; i++) begin
            do_fill(16'($urandom),
                    ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 5)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BW - 1)) : -1);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
